memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Memory-access (M) pipeline stage of the display processor core; the consumer of the Execute stage's outputs.
//  - Registers the E->M pipeline fields.
//  - Issues loads/stores to the data-memory port over a req/ack handshake.
//  - Stalls the pipeline until ack arrives.
//  - Presents aligned, extended load data and the forwarded ALU result to writeback and hazard logic.
// PARAMETERS
//  (none; all datapaths are 32-bit, register index is 5-bit)
// PORTS
//  clk             in   1   rising-edge clock
//  reset_n         in   1   asynchronous, active-low reset
//  e_alu_result    in   32  effective address / ALU result from Execute
//  e_write_data    in   32  forwarded rs2 value (store data)
//  e_rd            in   5   destination register
//  e_pc_plus_4     in   32  link value
//  e_mem_read      in   1   instruction is a load
//  e_mem_write     in   1   instruction is a store (wins if both set)
//  e_mem_size      in   2   00 byte, 01 half, 10 word, 11 treated as word
//  e_mem_unsigned  in   1   zero-extend loads (LBU/LHU)
//  m_stall         out  1   freeze F/D/E and this stage's input register
//  m_alu_result    out  32  registered ALU result (forward path)
//  m_read_data     out  32  extended load data; 0 for non-loads
//  m_rd            out  5   registered destination register
//  m_pc_plus_4     out  32  registered link value
//  m_misaligned    out  1   misaligned access flag (see CONFIGURATION)
//  dmem_req        out  1   bus request, held until ack
//  dmem_we         out  1   1 = write
//  dmem_addr       out  32  word address {m_alu_result[31:2],2'b00}
//  dmem_wdata      out  32  lane-replicated store data
//  dmem_be         out  4   byte enables
//  dmem_ack        in   1   transfer complete, sampled on rising clk
//  dmem_rdata      in   32  read word, valid with dmem_ack
// BEHAVIOUR
//  - Reset: all M registers, m_read_data, FSM state to 0 (IDLE); every output 0 while reset_n low.
//  - Input register loads on every rising edge where m_stall=0; holds when m_stall=1.
//    Bubble = mem_read=mem_write=0 and rd=0.
//  - FSM states: IDLE, ACCESS.
//    - IDLE->ACCESS on an edge where m_stall=0 and the captured instruction is a (non-trapped) load/store.
//    - ACCESS->IDLE on an edge with dmem_ack=1.
//    - ACCESS with ack=0 stays in ACCESS.
//  - dmem_req = (state==ACCESS); dmem_we/addr/wdata/be are driven from the M registers and stay stable while req=1.
//  - m_stall = (state==ACCESS). This is combinational; it does not depend on dmem_ack.
//  - Latency:
//    - Non-memory ops occupy M for 1 cycle.
//    - Memory ops occupy M for 1 + N cycles, where N>=1 is the number of ACCESS cycles up to and including the ack cycle.
//    - Ack in the first ACCESS cycle gives 2 cycles total.
//  - Load capture: on the ack edge, m_read_data <= extend(lane(dmem_rdata, addr[1:0], size)).
//    - Byte: select byte addr[1:0].
//    - Half: select half addr[1].
//    - Sign-extend unless e_mem_unsigned.
//    - Cleared to 0 when a non-load enters M.
//  - Store lanes:
//    - Byte: wdata={4{wd[7:0]}}, be=4'b0001<<addr[1:0].
//    - Half: wdata={2{wd[15:0]}}, be=4'b0011<<{addr[1],1'b0}.
//    - Word: wdata=wd, be=4'b1111.
//    - Loads drive be=4'b1111, we=0.
//  - dmem_ack while dmem_req=0 is ignored. dmem_rdata is ignored when ack=0 or we=1.
//  - Back-to-back memory ops: the ack edge returns to IDLE; the next op enters M one cycle later (one IDLE cycle between requests).
//  - reset_n asserted mid-ACCESS: dmem_req drops asynchronously, the transaction is abandoned, no data is captured.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN
//  - Defined:
//    - Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
//    - Such an access issues no request and does not enter ACCESS.
//    - m_misaligned=1 for its single cycle in M; m_read_data=0.
//  - Undefined:
//    - m_misaligned tied 0.
//    - Low address bits are used only as above, so access is truncated (e.g. half at addr 0x3 gives be=4'b1100).
// TESTING
//  1. LW at 0x100, ack 1st ACCESS cycle, rdata=0xDEADBEEF -> req high 1 cycle, addr=0x100, be=1111,
//     m_stall high 1 cycle, m_read_data=0xDEADBEEF.
//  2. LB at 0x103, rdata=0x80FF0000 -> m_read_data=0xFFFFFF80. Same access as LBU -> 0x00000080.
//  3. SH 0x1234ABCD to 0x202, ack delayed 3 cycles -> wdata=0xABCDABCD, be=1100, we=1;
//     req/addr/wdata stable 3 cycles; F/D/E frozen (m_stall=1) 3 cycles.
//  4. SB, then LW, each acked immediately -> exactly one IDLE cycle between the two req pulses;
//     m_rd/m_alu_result track each instruction.
//  5. reset_n low during ACCESS -> req drops with no clock edge; all outputs 0;
//     a stale ack after release is ignored.
//  6. LW at 0x102:
//     - MEM_MISALIGN_TRAP_EN defined -> no req, m_misaligned=1 for 1 cycle, m_stall=0.
//     - MEM_MISALIGN_TRAP_EN undefined -> req issued with addr=0x100, m_misaligned=0.

Source files
------------

// File: rtl/memory_stage.sv
// Memory-access stage: registers E->M fields, runs the dmem req/ack
// handshake, stalls the pipe during ACCESS and extends load data.
//
// Ports (spec names kept as-is):
//   clk, reset_n          clock, async active-low reset
//   e_*                   Execute-stage fields captured when m_stall=0
//   m_stall               freeze F/D/E and the M input register
//   m_alu_result/m_rd/m_pc_plus_4  registered forward/writeback fields
//   m_read_data           extended load data, 0 for non-loads
//   m_misaligned          misaligned-access flag
//   dmem_*                data-memory bus (req held until ack)
//
// Build option: MEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
// accesses issue no request and raise m_misaligned for their M cycle.
// When undefined, m_misaligned is 0 and unaligned accesses are truncated.

module memory_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] e_alu_result,
    input  logic [31:0] e_write_data,
    input  logic [4:0]  e_rd,
    input  logic [31:0] e_pc_plus_4,
    input  logic        e_mem_read,
    input  logic        e_mem_write,
    input  logic [1:0]  e_mem_size,
    input  logic        e_mem_unsigned,
    output logic        m_stall,
    output logic [31:0] m_alu_result,
    output logic [31:0] m_read_data,
    output logic [4:0]  m_rd,
    output logic [31:0] m_pc_plus_4,
    output logic        m_misaligned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] alu_q, wd_q, pc4_q;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q;
    logic [1:0]  size_q;
    logic        ld_q, st_q, uns_q, mis_q;

    logic        e_ld, e_st, e_mis, cap;
    logic [31:0] sh_b, sh_h, ext;

    // Store wins when both read and write are flagged.
    assign e_st = e_mem_write;
    assign e_ld = e_mem_read & ~e_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        e_mis = 1'b0;
        if (e_ld | e_st) begin
            unique case (e_mem_size)
                2'b00:   e_mis = 1'b0;
                2'b01:   e_mis = e_alu_result[0];
                default: e_mis = |e_alu_result[1:0];
            endcase
        end
    end
`else
    assign e_mis = 1'b0;
`endif

    // The input register only advances while nothing is in flight.
    assign cap = (state_q == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_q  <= '0;
            wd_q   <= '0;
            pc4_q  <= '0;
            rd_q   <= '0;
            size_q <= '0;
            ld_q   <= 1'b0;
            st_q   <= 1'b0;
            uns_q  <= 1'b0;
            mis_q  <= 1'b0;
        end else if (cap) begin
            alu_q  <= e_alu_result;
            wd_q   <= e_write_data;
            pc4_q  <= e_pc_plus_4;
            rd_q   <= e_rd;
            size_q <= e_mem_size;
            ld_q   <= e_ld & ~e_mis;
            st_q   <= e_st & ~e_mis;
            uns_q  <= e_mem_unsigned;
            mis_q  <= e_mis;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if ((e_ld | e_st) && !e_mis) state_d = ACCESS;
            ACCESS: if (dmem_ack) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Lane select: byte by addr[1:0], half by addr[1].
    assign sh_b = dmem_rdata >> {alu_q[1:0], 3'b000};
    assign sh_h = dmem_rdata >> {alu_q[1], 4'b0000};

    always_comb begin
        ext = dmem_rdata;
        unique case (size_q)
            2'b00: ext = uns_q ? {24'b0, sh_b[7:0]}
                               : {{24{sh_b[7]}}, sh_b[7:0]};
            2'b01: ext = uns_q ? {16'b0, sh_h[15:0]}
                               : {{16{sh_h[15]}}, sh_h[15:0]};
            default: ext = dmem_rdata;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (cap)
            rdata_d = '0;
        else if (dmem_ack && ld_q)
            rdata_d = ext;
    end

    always_comb begin
        dmem_wdata = wd_q;
        dmem_be    = 4'b0000;
        unique case (size_q)
            2'b00:   dmem_wdata = {4{wd_q[7:0]}};
            2'b01:   dmem_wdata = {2{wd_q[15:0]}};
            default: dmem_wdata = wd_q;
        endcase
        if (st_q) begin
            unique case (size_q)
                2'b00:   dmem_be = 4'b0001 << alu_q[1:0];
                2'b01:   dmem_be = 4'b0011 << {alu_q[1], 1'b0};
                default: dmem_be = 4'b1111;
            endcase
        end else if (ld_q) begin
            dmem_be = 4'b1111;
        end
    end

    assign m_stall      = (state_q == ACCESS);
    assign dmem_req     = (state_q == ACCESS);
    assign dmem_we      = st_q;
    assign dmem_addr    = {alu_q[31:2], 2'b00};
    assign m_alu_result = alu_q;
    assign m_read_data  = rdata_q;
    assign m_rd         = rd_q;
    assign m_pc_plus_4  = pc4_q;
    assign m_misaligned = mis_q;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed cases plus random instruction
// stream checked against a transaction-level reference model.

module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] e_alu_result, e_write_data, e_pc_plus_4;
    logic [4:0]  e_rd;
    logic        e_mem_read, e_mem_write, e_mem_unsigned;
    logic [1:0]  e_mem_size;
    logic        m_stall, m_misaligned;
    logic [31:0] m_alu_result, m_read_data, m_pc_plus_4;
    logic [4:0]  m_rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int total = 0;
    int bad   = 0;

    memory_stage dut (
        .clk(clk), .reset_n(reset_n),
        .e_alu_result(e_alu_result), .e_write_data(e_write_data),
        .e_rd(e_rd), .e_pc_plus_4(e_pc_plus_4),
        .e_mem_read(e_mem_read), .e_mem_write(e_mem_write),
        .e_mem_size(e_mem_size), .e_mem_unsigned(e_mem_unsigned),
        .m_stall(m_stall), .m_alu_result(m_alu_result),
        .m_read_data(m_read_data), .m_rd(m_rd),
        .m_pc_plus_4(m_pc_plus_4), .m_misaligned(m_misaligned),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble();
        e_alu_result   = $urandom;
        e_write_data   = $urandom;
        e_pc_plus_4    = $urandom;
        e_rd           = 5'($urandom);
        e_mem_read     = 1'($urandom);
        e_mem_write    = 1'($urandom);
        e_mem_size     = 2'($urandom);
        e_mem_unsigned = 1'($urandom);
    endtask

    task automatic bubble();
        e_alu_result = '0; e_write_data = '0; e_pc_plus_4 = '0;
        e_rd = '0; e_mem_read = 1'b0; e_mem_write = 1'b0;
        e_mem_size = '0; e_mem_unsigned = 1'b0;
    endtask

    // Issue one instruction into M and check it through to its last
    // M cycle. n = number of ACCESS cycles before ack (>=1).
    task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc4,
                         input logic rf, input logic wf,
                         input logic [1:0] sz, input logic un,
                         input int n, input logic [31:0] rdx);
        logic        mem, ld, trap;
        int          bytes, off, base;
        logic [3:0]  be;
        logic [31:0] wdx, sh, msk, val;
        mem   = rf | wf;
        ld    = rf & ~wf;
        bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off   = int'(a[1:0]);
        base  = off - (off % bytes);
        trap  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap  = mem && (off % bytes != 0);
`endif
        be = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= base && i < base + bytes) be[i] = 1'b1;
        if (ld) be = 4'b1111;
        for (int i = 0; i < 4; i++)
            wdx[8*i +: 8] = wd[8*(i % bytes) +: 8];
        sh  = rdx >> (8 * base);
        msk = (bytes == 4) ? 32'hffff_ffff
                           : (32'h1 << (8 * bytes)) - 32'h1;
        val = sh & msk;
        if (!un && bytes < 4 && val[8*bytes-1]) val = val | ~msk;

        e_alu_result = a; e_write_data = wd; e_rd = rd;
        e_pc_plus_4 = pc4; e_mem_read = rf; e_mem_write = wf;
        e_mem_size = sz; e_mem_unsigned = un;
        dmem_rdata = $urandom;
        dmem_ack   = mem ? 1'b0 : 1'($urandom);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("m_rd", 32'(m_rd), 32'(rd));
        chk("m_alu", m_alu_result, a);
        chk("m_pc4", m_pc_plus_4, pc4);
        chk("misal", 32'(m_misaligned), 32'(trap));
        if (mem && !trap) begin
            for (int c = 1; c <= n; c++) begin
                chk("stall_acc", 32'(m_stall), 32'd1);
                chk("req_acc", 32'(dmem_req), 32'd1);
                chk("addr", dmem_addr, {a[31:2], 2'b00});
                chk("we", 32'(dmem_we), 32'(wf));
                chk("be", 32'(dmem_be), 32'(be));
                if (wf) chk("wdata", dmem_wdata, wdx);
                scramble();
                dmem_rdata = $urandom;
                if (c == n) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdx;
                end
                @(posedge clk); #1;
                dmem_ack = 1'b0;
            end
        end
        chk("stall_end", 32'(m_stall), 32'd0);
        chk("req_end", 32'(dmem_req), 32'd0);
        chk("rdata", m_read_data, (ld && !trap) ? val : 32'd0);
        chk("m_rd_hold", 32'(m_rd), 32'(rd));
    endtask

    initial begin
        reset_n  = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        bubble();
        #2;
        chk("rst_stall", 32'(m_stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_alu", m_alu_result, 32'd0);
        chk("rst_rdata", m_read_data, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_rd", 32'(m_rd), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // LW 0x100, immediate ack
        issue(32'h100, 32'h0, 5'd1, 32'h4, 1, 0, 2'b10, 0, 1,
              32'hDEADBEEF);
        // LB / LBU at 0x103
        issue(32'h103, 32'h0, 5'd2, 32'h8, 1, 0, 2'b00, 0, 1,
              32'h80FF0000);
        issue(32'h103, 32'h0, 5'd3, 32'hC, 1, 0, 2'b00, 1, 1,
              32'h80FF0000);
        // SH to 0x202, ack after 3 cycles
        issue(32'h202, 32'h1234ABCD, 5'd0, 32'h10, 0, 1, 2'b01, 0, 3,
              32'h0);
        // SB then LW back to back
        issue(32'h301, 32'h55, 5'd0, 32'h14, 0, 1, 2'b00, 0, 1, 32'h0);
        issue(32'h304, 32'h0, 5'd7, 32'h18, 1, 0, 2'b10, 0, 1,
              32'hCAFEF00D);
        // ALU op after a load clears m_read_data
        issue(32'h12345678, 32'h0, 5'd9, 32'h1C, 0, 0, 2'b10, 0, 1,
              32'h0);
        // LW at 0x102 (trap or truncation depending on build)
        issue(32'h102, 32'h0, 5'd4, 32'h20, 1, 0, 2'b10, 0, 1,
              32'h11223344);
        // Half store at 0x3: truncated lanes when trapping is off
        issue(32'h3, 32'hBEEF, 5'd0, 32'h24, 0, 1, 2'b01, 0, 2, 32'h0);

        // Reset mid-ACCESS
        e_alu_result = 32'h100; e_mem_read = 1'b1; e_mem_write = 1'b0;
        e_mem_size = 2'b10; e_rd = 5'd5;
        @(posedge clk); #1;
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        bubble();
        #3 reset_n = 1'b0;
        #1;
        chk("arst_req", 32'(dmem_req), 32'd0);
        chk("arst_stall", 32'(m_stall), 32'd0);
        chk("arst_alu", m_alu_result, 32'd0);
        chk("arst_rd", 32'(m_rd), 32'd0);
        chk("arst_be", 32'(dmem_be), 32'd0);
        @(posedge clk); #1;
        reset_n    = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("stale_req", 32'(dmem_req), 32'd0);
        chk("stale_stall", 32'(m_stall), 32'd0);
        chk("stale_rdata", m_read_data, 32'd0);

        // Random stream
        for (int k = 0; k < 60; k++) begin
            issue($urandom, $urandom, 5'($urandom), $urandom,
                  1'($urandom), 1'($urandom), 2'($urandom),
                  1'($urandom), int'($urandom_range(1, 4)), $urandom);
        end

        bubble();
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
